// File: rtl/cd_pkg.sv
// Shared state encoding and frame/CSR constants for the CDBUS rx drain engine.
package cd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAT,
    ST_HDR,
    ST_STREAM,
    ST_FETCH,
    ST_RELEASE
  } cd_state_e;

  localparam int HDR_SRC   = 0;
  localparam int HDR_DST   = 1;
  localparam int HDR_LEN   = 2;
  localparam int HDR_BYTES = 3;

  localparam logic [7:0] MAX_DATA_LEN = 8'd253;

  localparam logic [3:0] DEF_CSR_INT_FLAG_ADDR = 4'd8;
  localparam logic [3:0] DEF_CSR_RX_CTRL_ADDR  = 4'd10;
  localparam int         DEF_RX_PEND_BIT       = 1;
  localparam int         DEF_RX_LOST_BIT       = 2;
  localparam int         DEF_RD_DONE_BIT       = 1;

endpackage

// File: rtl/cd_rx_drain.sv
// Host-side rx drain: polls CDBUS status, streams each received frame out as
// bytes, then hands the rx page back to the peripheral.
module cd_rx_drain
  import cd_pkg::*;
#(
  parameter int unsigned POLL_DIV          = 1024,
  parameter logic [3:0]  CSR_INT_FLAG_ADDR = DEF_CSR_INT_FLAG_ADDR,
  parameter logic [3:0]  CSR_RX_CTRL_ADDR  = DEF_CSR_RX_CTRL_ADDR,
  parameter int unsigned RX_PEND_BIT       = DEF_RX_PEND_BIT,
  parameter int unsigned RX_LOST_BIT       = DEF_RX_LOST_BIT,
  parameter int unsigned RD_DONE_BIT       = DEF_RD_DONE_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  input  logic [31:0] csr_readdata,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  output logic [3:0]  csr_byteenable,
  output logic [5:0]  rx_mm_address,
  output logic        rx_mm_read,
  input  logic [31:0] rx_mm_readdata,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [7:0]  lost_cnt,
  output logic        len_err
);

  localparam int            PW        = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [8:0] frame_total(input logic [7:0] len);
    logic [7:0] l;
    l = (len > MAX_DATA_LEN) ? MAX_DATA_LEN : len;
    return 9'(HDR_BYTES) + {1'b0, l};
  endfunction

  cd_state_e     r_state;
  logic [PW-1:0] r_poll_cnt;
  logic [7:0]    r_lost_cnt;
  logic          r_len_err;
  logic [31:0]   r_buf;
  logic [8:0]    r_k;
  logic [8:0]    r_t;

  logic       w_poll_req;
  logic       w_start;
  logic       w_stat_rd;
  logic       w_last;
  logic       w_fetch;
  logic       w_release;
  logic [8:0] w_k_nxt;
  logic [7:0] w_len;
  logic [7:0] w_lane;
  logic       w_unused;

  // Read strobes are issued in the cycle that decides them, so the following
  // state (STAT/HDR/FETCH) is exactly the cycle the read data is valid.
  assign w_poll_req = (POLL_DIV != 0) && (r_state == ST_IDLE) && (r_poll_cnt == POLL_LAST);
  assign w_start    = !reset && enable && (irq || w_poll_req) && (r_state == ST_IDLE);
  assign w_stat_rd  = !reset && (r_state == ST_STAT) && csr_readdata[RX_PEND_BIT];
  assign w_last     = (r_k == r_t - 9'd1);
  assign w_k_nxt    = r_k + 9'd1;
  assign w_fetch    = !reset && (r_state == ST_STREAM) && m_ready && !w_last && (r_k[1:0] == 2'd3);
  assign w_release  = !reset && (r_state == ST_RELEASE);
  assign w_len      = rx_mm_readdata[8*HDR_LEN +: 8];
  assign w_lane     = r_buf[{r_k[1:0], 3'b000} +: 8];
  assign w_unused   = ^csr_readdata;

  assign csr_read       = w_start;
  assign csr_write      = w_release;
  assign csr_address    = w_release ? CSR_RX_CTRL_ADDR : (w_start ? CSR_INT_FLAG_ADDR : 4'd0);
  assign csr_writedata  = w_release ? (32'd1 << RD_DONE_BIT) : 32'd0;
  assign csr_byteenable = 4'hF;
  assign rx_mm_read     = w_stat_rd || w_fetch;
  assign rx_mm_address  = w_fetch ? w_k_nxt[7:2] : 6'd0;
  assign m_valid        = (r_state == ST_STREAM);
  assign m_data         = m_valid ? w_lane : 8'd0;
  assign m_last         = m_valid && w_last;
  assign busy           = (r_state != ST_IDLE);
  assign lost_cnt       = r_lost_cnt;
  assign len_err        = r_len_err;

  // Control path: state, poll timer, lost counter, length-error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_poll_cnt <= '0;
      r_lost_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_STAT;
            r_poll_cnt <= '0;
          end else if (POLL_DIV != 0) begin
            r_poll_cnt <= w_poll_req ? '0 : r_poll_cnt + 1'b1;
          end
        end
        ST_STAT: begin
          if (csr_readdata[RX_LOST_BIT]) r_lost_cnt <= sat_inc8(r_lost_cnt);
          r_state <= csr_readdata[RX_PEND_BIT] ? ST_HDR : ST_IDLE;
        end
        ST_HDR: begin
          r_len_err <= (w_len > MAX_DATA_LEN);
          r_state   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (m_ready) begin
            if (w_last)                 r_state <= ST_RELEASE;
            else if (r_k[1:0] == 2'd3)  r_state <= ST_FETCH;
          end
        end
        ST_FETCH:   r_state <= ST_STREAM;
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Data path: word buffer, byte index and frame length need no reset; they
  // are always reloaded in HDR before STREAM looks at them.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_HDR: begin
        r_buf <= rx_mm_readdata;
        r_k   <= '0;
        r_t   <= frame_total(w_len);
      end
      ST_STREAM: if (m_ready) r_k <= w_k_nxt;
      ST_FETCH:  r_buf <= rx_mm_readdata;
      default: ;
    endcase
  end

endmodule
